// File: rtl/spi_cs_sequencer_if.sv
// Bus bundle for the chip-select sequencer: user byte stream on one side,
// SPI byte master handshake and chip select on the other.
interface spi_cs_sequencer_if;
    logic [7:0] i_TX_Count;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic [7:0] o_RX_Count;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic [7:0] o_M_TX_Byte;
    logic       o_M_TX_DV;
    logic       i_M_TX_Ready;
    logic       i_M_RX_DV;
    logic [7:0] i_M_RX_Byte;
    logic       o_SPI_CS_n;

    // Sequencer side
    modport slave (
        input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV,
               o_SPI_CS_n
    );

    // Environment side (user logic plus byte master)
    modport master (
        output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
        input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV,
               o_SPI_CS_n
    );
endinterface

// File: rtl/spi_cs_sequencer.sv
// Wraps an SPI byte master with chip-select framing: CS lead time before the
// first byte, CS held low across a multi-byte transaction, CS lag after the
// last byte and a minimum CS-high gap before the next transaction.
module spi_cs_sequencer #(
    parameter int CS_LEAD_CLKS = 2,
    parameter int CS_LAG_CLKS  = 2,
    parameter int CS_IDLE_CLKS = 4
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    spi_cs_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LEAD, ISSUE, WAIT, NEXT, LAG, GAP} state_t;

    // The lead window counts the ISSUE cycle as its last cycle, so the first
    // o_M_TX_DV lands exactly CS_LEAD_CLKS edges after CS falls when the byte
    // master is already idle. With a lead of 1, LEAD is skipped entirely.
    localparam logic [7:0] LEAD_LOAD = 8'((CS_LEAD_CLKS > 1) ? (CS_LEAD_CLKS - 2) : 0);
    localparam logic [7:0] LAG_LOAD  = 8'(CS_LAG_CLKS - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(CS_IDLE_CLKS - 1);

    state_t     state;
    logic [7:0] tmr;
    logic [7:0] remaining;
    logic [7:0] done_cnt;
    logic [7:0] tx_byte;
    logic       rx_prev;
    logic       rx_rise;

    // Byte master may hold RX_DV as a level; only its rising edge marks a byte.
    assign rx_rise = bus.i_M_RX_DV & ~rx_prev;

    // Previous-value register for the receive-valid edge detector
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) rx_prev <= 1'b0;
        else          rx_prev <= bus.i_M_RX_DV;
    end

    // Transaction FSM with registered handshake, data and chip-select outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state           <= IDLE;
            tmr             <= 8'd0;
            remaining       <= 8'd0;
            done_cnt        <= 8'd0;
            tx_byte         <= 8'd0;
            bus.o_SPI_CS_n  <= 1'b1;
            bus.o_TX_Ready  <= 1'b0;
            bus.o_M_TX_DV   <= 1'b0;
            bus.o_M_TX_Byte <= 8'd0;
            bus.o_RX_DV     <= 1'b0;
            bus.o_RX_Byte   <= 8'd0;
            bus.o_RX_Count  <= 8'd0;
        end else begin
            bus.o_M_TX_DV <= 1'b0;
            bus.o_RX_DV   <= 1'b0;
            case (state)
                IDLE: begin
                    bus.o_SPI_CS_n <= 1'b1;
                    if (bus.i_TX_DV && bus.o_TX_Ready && (bus.i_TX_Count != 8'd0)) begin
                        remaining      <= bus.i_TX_Count;
                        done_cnt       <= 8'd0;
                        tx_byte        <= bus.i_TX_Byte;
                        bus.o_TX_Ready <= 1'b0;
                        bus.o_SPI_CS_n <= 1'b0;
                        tmr            <= LEAD_LOAD;
                        state          <= (CS_LEAD_CLKS > 1) ? LEAD : ISSUE;
                    end else begin
                        bus.o_TX_Ready <= 1'b1;
                    end
                end
                LEAD: begin
                    if (tmr == 8'd0) state <= ISSUE;
                    else             tmr   <= tmr - 8'd1;
                end
                ISSUE: begin
                    if (bus.i_M_TX_Ready) begin
                        bus.o_M_TX_Byte <= tx_byte;
                        bus.o_M_TX_DV   <= 1'b1;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (rx_rise) begin
                        bus.o_RX_DV    <= 1'b1;
                        bus.o_RX_Byte  <= bus.i_M_RX_Byte;
                        bus.o_RX_Count <= done_cnt;
                        done_cnt       <= done_cnt + 8'd1;
                        remaining      <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            tmr   <= LAG_LOAD;
                            state <= LAG;
                        end else begin
                            bus.o_TX_Ready <= 1'b1;
                            state          <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    // CS stays low; the count was fixed by the first byte.
                    if (bus.i_TX_DV) begin
                        tx_byte        <= bus.i_TX_Byte;
                        bus.o_TX_Ready <= 1'b0;
                        state          <= ISSUE;
                    end
                end
                LAG: begin
                    if (tmr == 8'd0) begin
                        bus.o_SPI_CS_n <= 1'b1;
                        tmr            <= GAP_LOAD;
                        state          <= GAP;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                GAP: begin
                    if (tmr == 8'd0) begin
                        bus.o_TX_Ready <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: begin
                    bus.o_SPI_CS_n <= 1'b1;
                    bus.o_TX_Ready <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer with a behavioural SPI byte master and a
// scoreboard of expected master bytes and received bytes/indices.
module tb_spi_cs_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_cs_sequencer_if bus ();

    spi_cs_sequencer #(.CS_LEAD_CLKS(2), .CS_LAG_CLKS(2), .CS_IDLE_CLKS(4)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int cs_falls = 0, cs_rises = 0, tx_cnt = 0, rx_cnt = 0;
    int cs_fall_cyc = 0, cs_rise_cyc = 0, rdy_rise_cyc = 0, tx_cyc = 0, rx_cyc = 0;
    int acc_cyc = 0, mrdy_cyc = 0;
    int hold = 0, mdl_cnt = 0, lvl = 0, rx_len = 1;
    bit arm_hold = 1'b0;
    logic prev_cs = 1'b1, prev_rdy = 1'b0, prev_mdv = 1'b0;
    logic [7:0] mdl_resp = 8'd0;
    logic [7:0] idx = 8'd0;
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_rx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample outputs 1ns after the edge, score them, advance the
    // byte master model and drive its inputs for the next edge.
    task automatic tick();
        logic [15:0] e;
        logic [7:0]  b;
        @(posedge clk); #1;
        cyc++;
        if (prev_cs && !bus.o_SPI_CS_n) begin
            cs_falls++; cs_fall_cyc = cyc;
            if (arm_hold) begin arm_hold = 1'b0; hold = 11; bus.i_M_TX_Ready = 1'b0; end
        end
        if (!prev_cs && bus.o_SPI_CS_n) begin cs_rises++; cs_rise_cyc = cyc; end
        if (!prev_rdy && bus.o_TX_Ready) rdy_rise_cyc = cyc;
        if (bus.o_M_TX_DV) begin
            chk("mtx_single_cycle", 32'(prev_mdv), 32'd0);
            chk("mtx_cs_low", 32'(bus.o_SPI_CS_n), 32'd0);
            chk("mtx_ready_low", 32'(bus.o_TX_Ready), 32'd0);
            chk("mtx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) begin
                b = exp_tx.pop_front();
                chk("mtx_byte", 32'(bus.o_M_TX_Byte), 32'(b));
            end
            tx_cnt++; tx_cyc = cyc;
            mdl_resp = bus.o_M_TX_Byte ^ 8'h99;
            mdl_cnt = 3;
            bus.i_M_TX_Ready = 1'b0;
        end
        if (bus.o_RX_DV) begin
            rx_cnt++; rx_cyc = cyc;
            chk("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
            if (exp_rx.size() != 0) begin
                e = exp_rx.pop_front();
                chk("rx_byte", 32'(bus.o_RX_Byte), 32'(e[15:8]));
                chk("rx_count", 32'(bus.o_RX_Count), 32'(e[7:0]));
            end
        end
        if (hold > 0) begin
            hold--;
            if (hold == 0) begin bus.i_M_TX_Ready = 1'b1; mrdy_cyc = cyc; end
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                bus.i_M_RX_DV = 1'b1; bus.i_M_RX_Byte = mdl_resp; lvl = rx_len;
            end
        end else if (lvl > 0) begin
            lvl--;
            if (lvl == 0) begin bus.i_M_RX_DV = 1'b0; bus.i_M_TX_Ready = 1'b1; end
        end
        prev_cs = bus.o_SPI_CS_n; prev_rdy = bus.o_TX_Ready; prev_mdv = bus.o_M_TX_DV;
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.o_TX_Ready) begin ok = 1'b1; break; end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_rx.size() == 0 && bus.o_SPI_CS_n && bus.o_TX_Ready) begin ok = 1'b1; break; end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic start(input logic [7:0] cnt, input logic [7:0] b);
        wait_ready("tmo_start");
        bus.i_TX_Count = cnt; bus.i_TX_Byte = b; bus.i_TX_DV = 1'b1;
        exp_tx.push_back(b); exp_rx.push_back({b ^ 8'h99, 8'd0}); idx = 8'd1;
        tick();
        bus.i_TX_DV = 1'b0; acc_cyc = cyc;
    endtask

    task automatic next(input logic [7:0] b);
        wait_ready("tmo_next");
        bus.i_TX_Count = 8'd0; bus.i_TX_Byte = b; bus.i_TX_DV = 1'b1;
        exp_tx.push_back(b); exp_rx.push_back({b ^ 8'h99, idx}); idx++;
        tick();
        bus.i_TX_DV = 1'b0;
    endtask

    initial begin
        int f0, r0, t0, x0;
        bit ok;
        bus.i_TX_Count = 8'd0; bus.i_TX_Byte = 8'd0; bus.i_TX_DV = 1'b0;
        bus.i_M_TX_Ready = 1'b1; bus.i_M_RX_DV = 1'b0; bus.i_M_RX_Byte = 8'd0;

        // Reset values, then ready on first edge after release
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        chk("rst_ready", 32'(bus.o_TX_Ready), 32'd0);
        chk("rst_mtx_dv", 32'(bus.o_M_TX_DV), 32'd0);
        chk("rst_rx_dv", 32'(bus.o_RX_DV), 32'd0);
        chk("rst_rx_byte", 32'(bus.o_RX_Byte), 32'd0);
        chk("rst_rx_count", 32'(bus.o_RX_Count), 32'd0);
        chk("rst_mtx_byte", 32'(bus.o_M_TX_Byte), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        chk("ready_before_edge", 32'(bus.o_TX_Ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(bus.o_TX_Ready), 32'd1);

        // Single byte 0xA5 -> 0x3C with CS lead/lag/gap timing
        start(8'd1, 8'hA5);
        chk("cs_fall_at_accept", 32'(cs_fall_cyc), 32'(acc_cyc));
        chk("busy_after_accept", 32'(bus.o_TX_Ready), 32'd0);
        wait_done("tmo_single");
        chk("lead_clks", 32'(tx_cyc - cs_fall_cyc), 32'd2);
        chk("lag_clks", 32'(cs_rise_cyc - rx_cyc), 32'd2);
        chk("gap_clks", 32'(rdy_rise_cyc - cs_rise_cyc), 32'd4);

        // Three bytes under one CS pulse
        f0 = cs_falls; r0 = cs_rises; x0 = rx_cnt;
        start(8'd3, 8'h01);
        next(8'h02);
        next(8'h03);
        wait_done("tmo_three");
        chk("three_cs_falls", 32'(cs_falls - f0), 32'd1);
        chk("three_cs_rises", 32'(cs_rises - r0), 32'd1);
        chk("three_rx", 32'(rx_cnt - x0), 32'd3);

        // Count 0 ignored; stray master RX edge in IDLE ignored
        f0 = cs_falls; t0 = tx_cnt; x0 = rx_cnt;
        bus.i_TX_Count = 8'd0; bus.i_TX_Byte = 8'h55; bus.i_TX_DV = 1'b1;
        tick();
        bus.i_TX_DV = 1'b0;
        bus.i_M_RX_DV = 1'b1; bus.i_M_RX_Byte = 8'hEE;
        tick(); tick();
        bus.i_M_RX_DV = 1'b0;
        tick(); tick();
        chk("cnt0_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        chk("cnt0_ready", 32'(bus.o_TX_Ready), 32'd1);
        chk("cnt0_no_fall", 32'(cs_falls - f0), 32'd0);
        chk("cnt0_no_mtx", 32'(tx_cnt - t0), 32'd0);
        chk("stray_rx_ignored", 32'(rx_cnt - x0), 32'd0);

        // i_TX_DV while busy in LEAD is ignored
        start(8'd1, 8'h77);
        bus.i_TX_Count = 8'd2; bus.i_TX_Byte = 8'hEE; bus.i_TX_DV = 1'b1;
        tick();
        bus.i_TX_DV = 1'b0;
        wait_done("tmo_busy");
        chk("busy_one_mtx", 32'(tx_cnt - t0), 32'd1);
        chk("busy_one_cs", 32'(cs_falls - f0), 32'd1);

        // Byte master not ready for 10 edges in ISSUE
        arm_hold = 1'b1;
        start(8'd1, 8'h5A);
        wait_done("tmo_hold");
        chk("hold_issue_on_ready", 32'(tx_cyc - mrdy_cyc), 32'd1);
        chk("hold_total_delay", 32'(tx_cyc - cs_fall_cyc), 32'd11);

        // Level-style RX valid held for 5 cycles
        rx_len = 5; x0 = rx_cnt;
        start(8'd1, 8'hC3);
        wait_done("tmo_level");
        chk("level_one_rx", 32'(rx_cnt - x0), 32'd1);
        rx_len = 1;

        // Reset while waiting on byte 2 of 4
        t0 = tx_cnt;
        start(8'd4, 8'h10);
        next(8'h11);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_cnt - t0 == 2) begin ok = 1'b1; break; end
            tick();
        end
        chk("tmo_byte2", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs", 32'(bus.o_SPI_CS_n), 32'd1);
        chk("midrst_ready", 32'(bus.o_TX_Ready), 32'd0);
        exp_tx.delete(); exp_rx.delete();
        mdl_cnt = 0; lvl = 0; hold = 0;
        bus.i_M_RX_DV = 1'b0; bus.i_M_TX_Ready = 1'b1;
        x0 = rx_cnt;
        tick(); tick(); tick();
        chk("midrst_no_rx", 32'(rx_cnt - x0), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_back", 32'(bus.o_TX_Ready), 32'd1);
        start(8'd1, 8'h42);
        wait_done("tmo_after_rst");
        chk("after_rst_rx", 32'(rx_cnt - x0), 32'd1);
        chk("scoreboard_empty", 32'(exp_rx.size() + exp_tx.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_cs_sequencer.md
SPI_CS_SEQUENCER -- requirements
Module: spi_cs_sequencer

Interface
REQ-001 Parameter CS_LEAD_CLKS, default 2: i_Clk cycles from o_SPI_CS_n falling to first o_M_TX_DV (legal 1..255).
REQ-002 Parameter CS_LAG_CLKS, default 2: i_Clk cycles from last byte received to o_SPI_CS_n rising (legal 1..255).
REQ-003 Parameter CS_IDLE_CLKS, default 4: minimum i_Clk cycles o_SPI_CS_n stays high between transactions (legal 1..255).
REQ-004 i_Clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 i_TX_Count  in  8  bytes in transaction; sampled only with the first i_TX_DV of a transaction.
REQ-007 i_TX_Byte  in  8  byte to send; sampled with i_TX_DV.
REQ-008 i_TX_DV  in  1  single-cycle byte valid; honoured only while o_TX_Ready=1.
REQ-009 o_TX_Ready  out  1  sequencer accepts next i_TX_DV.
REQ-010 o_RX_Count  out  8  0-based index of the byte on o_RX_Byte.
REQ-011 o_RX_DV  out  1  single-cycle pulse, o_RX_Byte/o_RX_Count valid.
REQ-012 o_RX_Byte  out  8  received byte.
REQ-013 o_M_TX_Byte  out  8  byte to SPI byte master.
REQ-014 o_M_TX_DV  out  1  single-cycle start pulse to byte master.
REQ-015 i_M_TX_Ready  in  1  byte master idle.
REQ-016 i_M_RX_DV  in  1  byte master receive valid; pulse or level; rising edge = byte done.
REQ-017 i_M_RX_Byte  in  8  byte master received data.
REQ-018 o_SPI_CS_n  out  1  active-low chip select, registered.

Function
REQ-019 States: IDLE, LEAD, ISSUE, WAIT, NEXT, LAG, GAP; one-hot or binary, registered.
REQ-020 IDLE: o_SPI_CS_n=1, o_TX_Ready=1; i_TX_DV with i_TX_Count!=0 -> latch count and byte, o_TX_Ready=0 and o_SPI_CS_n=0 at next edge, go LEAD.
REQ-021 i_TX_DV with i_TX_Count=0 in IDLE: ignored, no CS activity, o_TX_Ready stays 1.
REQ-022 LEAD: stay exactly CS_LEAD_CLKS cycles, then ISSUE.
REQ-023 ISSUE: when i_M_TX_Ready=1, drive o_M_TX_DV=1 for exactly one cycle with o_M_TX_Byte = latched byte, go WAIT; otherwise hold in ISSUE.
REQ-024 WAIT: on rising edge of i_M_RX_DV (registered previous-value compare), pulse o_RX_DV one cycle with o_RX_Byte=i_M_RX_Byte and o_RX_Count=bytes done so far, then decrement remaining.
REQ-025 After receive, remaining=0 -> LAG; else -> NEXT with o_TX_Ready=1.
REQ-026 NEXT: CS held low; i_TX_DV latches byte, o_TX_Ready=0 next edge, go ISSUE; i_TX_Count ignored.
REQ-027 LAG: CS_LAG_CLKS cycles, then o_SPI_CS_n=1, go GAP.
REQ-028 GAP: CS_IDLE_CLKS cycles with o_TX_Ready=0, then IDLE.
REQ-029 i_TX_DV outside IDLE/NEXT: ignored, no state change.
REQ-030 i_M_RX_DV edge outside WAIT: ignored, no o_RX_DV.
REQ-031 Count 255 legal; o_RX_Count runs 0..254, no wrap.
REQ-032 Timing counters 8 bits, reloaded on each state entry.
REQ-033 o_M_TX_DV never asserted while o_SPI_CS_n=1.

Reset
REQ-034 i_Rst_L=0 asynchronously forces IDLE, o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0, o_M_TX_Byte=0, counters and edge-detect register 0.
REQ-035 o_TX_Ready rises on first clock edge after i_Rst_L deasserts.
REQ-036 Reset mid-transaction: CS released immediately, pending byte discarded, no o_RX_DV.

Verification
REQ-037 Single byte: Count=1, Byte=0xA5, MISO model returns 0x3C -> CS low 1 cycle after DV, o_M_TX_DV 2 cycles later, one o_RX_DV with 0x3C/count 0, CS high 2 cycles after receive, o_TX_Ready back after 4 further cycles.
REQ-038 Three bytes 0x01,0x02,0x03: CS continuously low; o_RX_Count 0,1,2; o_TX_Ready high only between bytes; one CS pulse total.
REQ-039 Count=0 and i_TX_DV while busy: no CS change, no o_M_TX_DV, state unchanged.
REQ-040 Byte master holds i_M_TX_Ready=0 for 10 cycles in ISSUE: o_M_TX_DV delayed exactly until ready, still single cycle.
REQ-041 Level-style i_M_RX_DV held high 5 cycles: exactly one o_RX_DV.
REQ-042 Reset asserted in WAIT of byte 2 of 4: o_SPI_CS_n=1 same cycle, IDLE after release, new 1-byte transaction completes normally.
